sad_dp: RTL



---
 rtl/sad_dp_if.sv | 20 ++
 rtl/sad_dp.sv | 104 ++++++++++
 2 files changed

// File: rtl/sad_dp_if.sv
// Control bus between the SAD controller FSM (master) and the SAD datapath (slave).
interface sad_dp_if;
  logic sum_clr;
  logic sum_ld;
  logic i_clr;
  logic i_inc;
  logic sad_reg_ld;
  logic min_clr;
  logic i_lt_256;

  modport master (
    output sum_clr, sum_ld, i_clr, i_inc, sad_reg_ld, min_clr,
    input  i_lt_256
  );

  modport slave (
    input  sum_clr, sum_ld, i_clr, i_inc, sad_reg_ld, min_clr,
    output i_lt_256
  );
endinterface

// File: rtl/sad_dp.sv
// SAD datapath: 9-bit block index, |A-B| accumulator, SAD register and protocol error flag.
// Optional minimum-SAD tracker is enabled by defining SAD_MINTRACK_EN.
module sad_dp #(
  parameter int PIX_W = 8,
  parameter int SUM_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  sad_dp_if.slave          ctl,
  output logic [7:0]       addr_o,
  input  logic [PIX_W-1:0] pa_i,
  input  logic [PIX_W-1:0] pb_i,
  output logic [SUM_W-1:0] sad_o,
  output logic             sad_vld_o,
  output logic             err_o,
  output logic [SUM_W-1:0] min_sad_o
);

  localparam logic [8:0] I_END = 9'd256;

  // A full block of maximal differences must fit in the accumulator.
  if (SUM_W < PIX_W + 8) begin : g_bad_width
    $error("sad_dp: SUM_W too narrow for 256 * (2^PIX_W - 1)");
  end

  logic [8:0]              i_q, i_d;
  logic [SUM_W-1:0]        sum_q, sum_d;
  logic [SUM_W-1:0]        sad_q, sad_d;
  logic                    vld_q;
  logic                    err_q, err_d;
  logic                    i_full;
  logic signed [PIX_W:0]   diff;
  logic [PIX_W-1:0]        abs_diff;

  assign i_full       = (i_q == I_END);
  assign ctl.i_lt_256 = (i_q < I_END);
  assign addr_o       = i_q[7:0];
  assign sad_o        = sad_q;
  assign sad_vld_o    = vld_q;
  assign err_o        = err_q;

  // NOTE: every variable gets a default at the top so no path leaves one unassigned (no latch).
  always_comb begin
    i_d      = i_q;
    sum_d    = sum_q;
    err_d    = err_q;
    sad_d    = sad_q;
    diff     = $signed({1'b0, pa_i}) - $signed({1'b0, pb_i});
    abs_diff = PIX_W'(diff[PIX_W] ? -diff : diff);

    if (ctl.i_clr)                     i_d = '0;
    else if (ctl.i_inc && !i_full)     i_d = i_q + 9'd1;

    if (ctl.sum_clr)                   sum_d = '0;
    else if (ctl.sum_ld && !i_full)    sum_d = sum_q + SUM_W'(abs_diff);

    // Stepping past the end of the block is a controller bug; the flag stays until i_clr.
    if (ctl.i_clr)                                  err_d = 1'b0;
    else if (i_full && (ctl.i_inc || ctl.sum_ld))   err_d = 1'b1;

    // Captures the pre-edge sum, so a same-cycle sum_clr does not affect what is latched.
    if (ctl.sad_reg_ld)                sad_d = sum_q;
  end

  // NOTE: non-blocking assignments in clocked blocks so all registers sample pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      i_q   <= '0;
      sum_q <= '0;
      sad_q <= '0;
      vld_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      i_q   <= i_d;
      sum_q <= sum_d;
      sad_q <= sad_d;
      vld_q <= ctl.sad_reg_ld;
      err_q <= err_d;
    end
  end

`ifdef SAD_MINTRACK_EN
  logic [SUM_W-1:0] min_q, min_d;

  always_comb begin
    min_d = min_q;
    if (ctl.min_clr)                               min_d = '1;
    else if (ctl.sad_reg_ld && (sum_q < min_q))    min_d = sum_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) min_q <= '1;
    else       min_q <= min_d;
  end

  assign min_sad_o = min_q;
`else
  logic unused_min_clr;

  assign unused_min_clr = ctl.min_clr;
  assign min_sad_o      = '1;
`endif

endmodule
